operator_unit_seq: RTL

//  Multi-cycle, parametrised arithmetic core that merges fixed add, fixed multiply, float multiply and float add.
//  It uses valid/ready handshakes on both the operand and result sides, and selects the operation per transaction.
//  It sits between the switch/operand registers and the display formatter on the Basys 3 build.

---
 rtl/operator_unit_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/operator_unit_seq.sv
// operator_unit_seq: multi-cycle fixed/float add and multiply core with valid/ready on both sides.
// Sequence is IDLE -> ALIGN -> OP -> NORM (float add may loop here) -> DONE.
module operator_unit_seq #(
  parameter int WIDTH    = 16,
  parameter int FIX_FRAC = 8,
  parameter int EXP_W    = 5,
  parameter int MAN_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);
  localparam int WW = 2 * WIDTH;
  localparam int XW = EXP_W + 3;
  localparam logic signed [XW-1:0] BIAS_X = XW'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [XW-1:0] EMAX_X = XW'(2 ** EXP_W - 1);
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);

  typedef enum logic [2:0] {IDLE, ALIGN, OP, NORM, DONE} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, result_q, result_d;
  logic [1:0]             mode_q, mode_d;
  logic                   overflow_q, overflow_d;
  logic [MAN_W:0]         x_q, x_d, y_q, y_d;
  logic [WW-1:0]          acc_q, acc_d;
  logic signed [XW-1:0]   exp_q, exp_d;
  logic                   sign_q, sign_d, sub_q, sub_d;

  logic [EXP_W-1:0] ea, eb, ediff;
  logic [MAN_W:0]   ma, mb;
  logic [MAN_W+1:0] addv;
  logic             za, zb, a_big;

  assign ea    = a_q[WIDTH-2 -: EXP_W];
  assign eb    = b_q[WIDTH-2 -: EXP_W];
  assign ma    = {1'b1, a_q[MAN_W-1:0]};
  assign mb    = {1'b1, b_q[MAN_W-1:0]};
  assign za    = ea == '0;
  assign zb    = eb == '0;
  assign a_big = a_q[WIDTH-2:0] >= b_q[WIDTH-2:0];
  assign ediff = a_big ? ea - eb : eb - ea;
  assign addv  = sub_q ? {1'b0, x_q} - {1'b0, y_q} : {1'b0, x_q} + {1'b0, y_q};

  // Returns {overflow, word}; saturates above the top exponent, flushes to +0 below 1.
  function automatic logic [WIDTH:0] pack(input logic s, input logic signed [XW-1:0] e,
                                          input logic [MAN_W-1:0] m);
    return (e > EMAX_X) ? {1'b1, s, {EXP_W{1'b1}}, {MAN_W{1'b1}}} :
           (e < ONE_X)  ? '0 : {1'b0, s, e[EXP_W-1:0], m};
  endfunction

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    x_d        = x_q;
    y_d        = y_q;
    acc_d      = acc_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    sub_d      = sub_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d        = op_a;
        b_d        = op_b;
        mode_d     = mode;
        overflow_d = 1'b0;
        state_d    = ALIGN;
      end
      ALIGN: begin
        x_d     = a_big ? ma : mb;
        y_d     = (a_big ? mb : ma) >> ediff;
        exp_d   = mode_q[0] ? XW'(a_big ? ea : eb) : XW'(ea) + XW'(eb) - BIAS_X;
        sign_d  = mode_q[0] ? (a_big ? a_q[WIDTH-1] : b_q[WIDTH-1]) : a_q[WIDTH-1] ^ b_q[WIDTH-1];
        sub_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        state_d = OP;
      end
      OP: begin
        acc_d   = mode_q == 2'b00 ? WW'(a_q) + WW'(b_q) :
                  mode_q == 2'b01 ? WW'(a_q) * WW'(b_q) :
                  mode_q == 2'b10 ? WW'(ma) * WW'(mb) : WW'(addv);
        state_d = NORM;
      end
      NORM: begin
        state_d = DONE;
        if (mode_q == 2'b00)
          {overflow_d, result_d} = acc_q[WIDTH:0];
        else if (mode_q == 2'b01)
          {overflow_d, result_d} = {|acc_q[WW-1:FIX_FRAC+WIDTH], acc_q[FIX_FRAC+WIDTH-1:FIX_FRAC]};
        else if (mode_q == 2'b10)
          {overflow_d, result_d} = (za || zb) ? '0 :
                                   acc_q[2*MAN_W+1] ? pack(sign_q, exp_q + ONE_X, acc_q[2*MAN_W -: MAN_W]) :
                                   pack(sign_q, exp_q, acc_q[2*MAN_W-1 -: MAN_W]);
        else if (za)
          {overflow_d, result_d} = {1'b0, b_q};
        else if (zb)
          {overflow_d, result_d} = {1'b0, a_q};
        else if (acc_q[MAN_W+1])
          {overflow_d, result_d} = pack(sign_q, exp_q + ONE_X, acc_q[MAN_W:1]);
        else if (acc_q[MAN_W:0] == '0)
          {overflow_d, result_d} = '0;
        else if (acc_q[MAN_W])
          {overflow_d, result_d} = pack(sign_q, exp_q, acc_q[MAN_W-1:0]);
        else begin
          acc_d   = acc_q << 1;
          exp_d   = exp_q - ONE_X;
          state_d = NORM;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      acc_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mode_q     <= mode_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      x_q        <= x_d;
      y_q        <= y_d;
      acc_q      <= acc_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      sub_q      <= sub_d;
    end
  end

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result    = result_q;
  assign overflow  = overflow_q;
endmodule
